// File: rtl/ysyx_22040632_csr_trap.sv
// rtl/ysyx_22040632_csr_trap.sv - machine-mode CSR file with trap and interrupt control
// Ports:
//   clk, rrst            clock, asynchronous active-high reset
//   rd_addr/rd_data/rd_ill   combinational CSR read port (ID)
//   wr_en/wr_addr/wr_data    CSR write commit (WB)
//   trap_*, mret_valid       trap entry / return commit (WB)
//   instret                  one instruction retired this cycle
//   irq_mtip/msip/meip       level interrupt lines
//   irq_pend/irq_cause       highest-priority enabled pending interrupt
//   trap_target, mepc_o      redirect pcs for trap entry and mret
module ysyx_22040632_csr_trap #(
  parameter int          XLEN    = 64,
  parameter int          PC_W    = 32,
  parameter int unsigned HARTID  = 0,
  parameter int          VECT_EN = 1
) (
  input  logic            clk,
  input  logic            rrst,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_ill,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [PC_W-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            instret,
  input  logic            irq_mtip,
  input  logic            irq_msip,
  input  logic            irq_meip,
  output logic            irq_pend,
  output logic [XLEN-1:0] irq_cause,
  output logic [PC_W-1:0] trap_target,
  output logic [PC_W-1:0] mepc_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  // MPP reads 11; on RV64 UXL/SXL are fixed at 2 (64-bit).
  localparam logic [63:0] MSTATUS_FIX64 = (XLEN == 64) ? 64'h0000_000A_0000_1800
                                                       : 64'h0000_0000_0000_1800;
  localparam logic [XLEN-1:0] MSTATUS_FIX = MSTATUS_FIX64[XLEN-1:0];

  logic            st_mie;
  logic            st_mpie;
  logic [XLEN-1:0] mie_r;
  logic [XLEN-3:0] mtvec_base;
  logic [1:0]      mtvec_mode;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-3:0] mepc_hi;      // mepc[1:0] is hardwired zero
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic            mip_meip;
  logic            mip_mtip;
  logic            mip_msip;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] mip_rd;
  logic [XLEN-1:0] mtvec_rd;
  logic [XLEN-1:0] mepc_full;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] target_full;
  logic [1:0]      wr_mode;

  always_comb begin
    mstatus_rd     = MSTATUS_FIX;
    mstatus_rd[7]  = st_mpie;
    mstatus_rd[3]  = st_mie;
    mip_rd         = '0;
    mip_rd[11]     = mip_meip;
    mip_rd[7]      = mip_mtip;
    mip_rd[3]      = mip_msip;
  end

  assign mtvec_rd  = {mtvec_base, mtvec_mode};
  assign mepc_full = {mepc_hi, 2'b00};
  assign mepc_o    = mepc_full[PC_W-1:0];

  // Vectored mode only offsets interrupts; exceptions always land on BASE.
  assign vec_off     = (mtvec_mode == 2'b01 && trap_cause[XLEN-1])
                       ? {trap_cause[XLEN-3:0], 2'b00} : '0;
  assign target_full = {mtvec_base, 2'b00} + vec_off;
  assign trap_target = target_full[PC_W-1:0];

  // MODE is WARL: anything other than a legal vectored request collapses to direct.
  assign wr_mode = (wr_data[1:0] == 2'b01 && VECT_EN != 0) ? 2'b01 : 2'b00;

  always_comb begin
    rd_data = '0;
    rd_ill  = 1'b0;
    case (rd_addr)
      A_MSTATUS:  rd_data = mstatus_rd;
      A_MIE:      rd_data = mie_r;
      A_MTVEC:    rd_data = mtvec_rd;
      A_MSCRATCH: rd_data = mscratch;
      A_MEPC:     rd_data = mepc_full;
      A_MCAUSE:   rd_data = mcause;
      A_MTVAL:    rd_data = mtval;
      A_MIP:      rd_data = mip_rd;
      A_MCYCLE:   rd_data = mcycle;
      A_MINSTRET: rd_data = minstret;
      A_MHARTID:  rd_data = XLEN'(HARTID);
      default:    rd_ill  = 1'b1;
    endcase
  end

  // Interrupt arbitration uses registered mip only, so irq lines see one cycle of latency.
  logic pend_e;
  logic pend_s;
  logic pend_t;

  assign pend_e = mip_meip & mie_r[11];
  assign pend_s = mip_msip & mie_r[3];
  assign pend_t = mip_mtip & mie_r[7];

  always_comb begin
    irq_pend  = st_mie & (pend_e | pend_s | pend_t);
    irq_cause = '0;
    if (irq_pend) begin
      irq_cause[XLEN-1] = 1'b1;
      if (pend_e)      irq_cause[3:0] = 4'd11;
      else if (pend_s) irq_cause[3:0] = 4'd3;
      else             irq_cause[3:0] = 4'd7;
    end
  end

  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_r      <= '0;
      mtvec_base <= '0;
      mtvec_mode <= 2'b00;
      mscratch   <= '0;
      mepc_hi    <= '0;
      mcause     <= '0;
      mtval      <= '0;
      mip_meip   <= 1'b0;
      mip_mtip   <= 1'b0;
      mip_msip   <= 1'b0;
      mcycle     <= '0;
      minstret   <= '0;
    end else begin
      mip_meip <= irq_meip;
      mip_mtip <= irq_mtip;
      mip_msip <= irq_msip;
      // Default counter advance; a committed CSR write below overrides it.
      mcycle   <= mcycle + XLEN'(1);
      minstret <= minstret + XLEN'(instret);
      if (trap_valid) begin
        mepc_hi <= XLEN'(trap_pc) >> 2;
        mcause  <= trap_cause;
        mtval   <= trap_tval;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_valid) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en) begin
        case (wr_addr)
          A_MSTATUS: begin
            st_mie  <= wr_data[3];
            st_mpie <= wr_data[7];
          end
          A_MIE:      mie_r    <= wr_data;
          A_MTVEC: begin
            mtvec_base <= wr_data[XLEN-1:2];
            mtvec_mode <= wr_mode;
          end
          A_MSCRATCH: mscratch <= wr_data;
          A_MEPC:     mepc_hi  <= wr_data[XLEN-1:2];
          A_MCAUSE:   mcause   <= wr_data;
          A_MTVAL:    mtval    <= wr_data;
          A_MCYCLE:   mcycle   <= wr_data;
          A_MINSTRET: minstret <= wr_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_csr_trap.sv
// tb/tb_ysyx_22040632_csr_trap.sv - self-checking bench for ysyx_22040632_csr_trap
module tb_ysyx_22040632_csr_trap;

  logic        clk = 1'b0;
  logic        rrst;
  logic [11:0] rd_addr;
  logic [63:0] rd_data;
  logic        rd_ill;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic        trap_valid;
  logic [63:0] trap_cause;
  logic [31:0] trap_pc;
  logic [63:0] trap_tval;
  logic        mret_valid;
  logic        instret;
  logic        irq_mtip, irq_msip, irq_meip;
  logic        irq_pend;
  logic [63:0] irq_cause;
  logic [31:0] trap_target;
  logic [31:0] mepc_o;

  ysyx_22040632_csr_trap #(.XLEN(64), .PC_W(32), .HARTID(0), .VECT_EN(1)) dut (
    .clk(clk), .rrst(rrst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ill(rd_ill),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .instret(instret),
    .irq_mtip(irq_mtip), .irq_msip(irq_msip), .irq_meip(irq_meip),
    .irq_pend(irq_pend), .irq_cause(irq_cause),
    .trap_target(trap_target), .mepc_o(mepc_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] impl_addrs [0:10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                     12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14};
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mip, m_mcycle, m_minstret;

  task automatic model_reset();
    m_mstatus  = 64'hA_0000_1800;
    m_mie      = 0; m_mtvec  = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause   = 0; m_mtval  = 0; m_mip      = 0; m_mcycle = 0; m_minstret = 0;
  endtask

  function automatic bit m_ill(input logic [11:0] a);
    foreach (impl_addrs[i]) if (impl_addrs[i] == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      default: return 64'd0;   // mhartid is 0, unimplemented reads 0
    endcase
  endfunction

  function automatic bit m_pend();
    return m_mstatus[3] && ((m_mip & m_mie) != 0);
  endfunction

  function automatic logic [63:0] m_irq_cause();
    int pri [3] = '{11, 3, 7};
    if (!m_pend()) return 64'd0;
    foreach (pri[i]) if (m_mip[pri[i]] && m_mie[pri[i]]) return (64'd1 << 63) | 64'(pri[i]);
    return 64'd0;
  endfunction

  function automatic logic [31:0] m_target(input logic [63:0] cause);
    logic [63:0] base, off, sum;
    base = m_mtvec & ~64'd3;
    off  = (m_mtvec[1:0] == 2'b01 && cause[63]) ? ({1'b0, cause[62:0]} * 4) : 64'd0;
    sum  = base + off;
    return sum[31:0];
  endfunction

  task automatic model_step();
    logic [63:0] cyc_n, ins_n;
    bit          old_mie, old_mpie;
    cyc_n = m_mcycle + 1;
    ins_n = m_minstret + 64'(instret);
    old_mie  = m_mstatus[3];
    old_mpie = m_mstatus[7];
    if (trap_valid) begin
      m_mepc    = 64'(trap_pc) & ~64'd3;
      m_mcause  = trap_cause;
      m_mtval   = trap_tval;
      m_mstatus = (m_mstatus & ~64'h88) | (old_mie ? 64'h80 : 64'h0);
    end else if (mret_valid) begin
      m_mstatus = (m_mstatus & ~64'h88) | 64'h80 | (old_mpie ? 64'h8 : 64'h0);
    end else if (wr_en) begin
      case (wr_addr)
        12'h300: m_mstatus  = (m_mstatus & ~64'h88) | (wr_data & 64'h88);
        12'h304: m_mie      = wr_data;
        12'h305: m_mtvec    = (wr_data & ~64'd3) | ((wr_data[1:0] == 2'b01) ? 64'd1 : 64'd0);
        12'h340: m_mscratch = wr_data;
        12'h341: m_mepc     = wr_data & ~64'd3;
        12'h342: m_mcause   = wr_data;
        12'h343: m_mtval    = wr_data;
        12'hB00: cyc_n      = wr_data;
        12'hB02: ins_n      = wr_data;
        default: ;
      endcase
    end
    m_mcycle   = cyc_n;
    m_minstret = ins_n;
    m_mip      = (64'(irq_meip) << 11) | (64'(irq_mtip) << 7) | (64'(irq_msip) << 3);
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (rrst) model_reset();
    else      model_step();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
    mret_valid = 0; instret = 0;
    irq_mtip = 0; irq_msip = 0; irq_meip = 0;
    rd_addr = 12'h300;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [63:0] exp);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  task automatic check_all(input int cyc);
    string s;
    s = $sformatf("rand%0d", cyc);
    chk({s, "_rd_data"},   rd_data,     m_read(rd_addr));
    chk({s, "_rd_ill"},    64'(rd_ill), 64'(m_ill(rd_addr)));
    chk({s, "_irq_pend"},  64'(irq_pend), 64'(m_pend()));
    chk({s, "_irq_cause"}, irq_cause,   m_irq_cause());
    chk({s, "_target"},    64'(trap_target), 64'(m_target(trap_cause)));
    chk({s, "_mepc_o"},    64'(mepc_o), m_mepc & 64'hFFFF_FFFF);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    bit          ill;
  } rd_vec_t;

  rd_vec_t rv [12];

  initial begin
    rv[0]  = '{12'h300, 64'hA_0000_1800, 1'b0};
    rv[1]  = '{12'hF14, 64'h0,           1'b0};
    rv[2]  = '{12'h7C0, 64'h0,           1'b1};
    rv[3]  = '{12'h304, 64'h0,           1'b0};
    rv[4]  = '{12'h305, 64'h0,           1'b0};
    rv[5]  = '{12'h341, 64'h0,           1'b0};
    rv[6]  = '{12'h342, 64'h0,           1'b0};
    rv[7]  = '{12'h344, 64'h0,           1'b0};
    rv[8]  = '{12'hB00, 64'h0,           1'b0};
    rv[9]  = '{12'hB02, 64'h0,           1'b0};
    rv[10] = '{12'h301, 64'h0,           1'b1};
    rv[11] = '{12'hF11, 64'h0,           1'b1};

    idle();
    rrst = 1;
    model_reset();
    repeat (3) tick();

    // reset state, held in reset so counters stay at zero
    for (int i = 0; i < 12; i++) begin
      rd_addr = rv[i].addr;
      #1;
      chk($sformatf("reset_rd_%0h", rv[i].addr), rd_data, rv[i].data);
      chk($sformatf("reset_ill_%0h", rv[i].addr), 64'(rd_ill), 64'(rv[i].ill));
    end
    chk("reset_irq_pend",  64'(irq_pend), 64'd0);
    chk("reset_irq_cause", irq_cause, 64'd0);
    chk("reset_mepc_o",    64'(mepc_o), 64'd0);
    tick();
    rrst = 0;

    // vectored interrupt target
    csr_wr(12'h305, 64'h8000_0001);
    csr_wr(12'h304, 64'h80);
    csr_wr(12'h300, 64'h8);
    irq_mtip = 1;
    #1;
    chk("irq_latency_pre", 64'(irq_pend), 64'd0);
    tick();
    chk("irq_pend_mtip", 64'(irq_pend), 64'd1);
    chk("irq_cause_mtip", irq_cause, 64'h8000_0000_0000_0007);
    trap_cause = 64'h8000_0000_0000_0007;
    #1;
    chk("trap_target_vec", 64'(trap_target), 64'h8000_001C);
    trap_cause = 64'd2;
    #1;
    chk("trap_target_exc", 64'(trap_target), 64'h8000_0000);

    // trap with colliding write: write is dropped
    trap_valid = 1; trap_cause = 64'd2; trap_pc = 32'h8000_0104; trap_tval = 64'hDEAD;
    wr_en = 1; wr_addr = 12'h341; wr_data = 64'h1234;
    tick();
    trap_valid = 0; wr_en = 0;
    rd_chk("trap_mepc",    12'h341, 64'h8000_0104);
    rd_chk("trap_mcause",  12'h342, 64'd2);
    rd_chk("trap_mtval",   12'h343, 64'hDEAD);
    rd_chk("trap_mstatus", 12'h300, 64'hA_0000_1880);
    chk("trap_irq_masked", 64'(irq_pend), 64'd0);

    // mret restores MIE
    mret_valid = 1;
    tick();
    mret_valid = 0;
    rd_chk("mret_mstatus", 12'h300, 64'hA_0000_1888);
    chk("mret_mepc_o", 64'(mepc_o), 64'h8000_0104);
    chk("mret_irq_pend", 64'(irq_pend), 64'd1);

    // mtvec WARL: mode 11 stores 00
    csr_wr(12'h305, 64'h4000_0103);
    rd_chk("mtvec_warl", 12'h305, 64'h4000_0100);

    // counter wrap and instret counting
    csr_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_chk("mcycle_loaded", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd_chk("mcycle_wrap", 12'hB00, 64'd0);
    csr_wr(12'hB02, 64'd0);
    instret = 1;
    repeat (10) tick();
    instret = 0;
    rd_chk("minstret_10", 12'hB02, 64'd10);

    // interrupt priority
    csr_wr(12'h304, 64'h888);
    irq_meip = 1; irq_msip = 1; irq_mtip = 1;
    tick();
    chk("prio_meip", irq_cause, 64'h8000_0000_0000_000B);
    irq_meip = 0;
    tick();
    chk("prio_msip", irq_cause, 64'h8000_0000_0000_0003);
    irq_msip = 0;
    tick();
    chk("prio_mtip", irq_cause, 64'h8000_0000_0000_0007);

    // randomized run against the model
    for (int c = 0; c < 400; c++) begin
      rd_addr    = ($urandom_range(0, 3) != 0) ? impl_addrs[$urandom_range(0, 10)] : 12'($urandom);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_addr    = ($urandom_range(0, 5) != 0) ? impl_addrs[$urandom_range(0, 10)] : 12'($urandom);
      wr_data    = {$urandom, $urandom};
      trap_valid = ($urandom_range(0, 9) == 0);
      trap_cause = {$urandom_range(0, 1) == 1, 59'd0, 4'($urandom)};
      trap_pc    = $urandom;
      trap_tval  = {$urandom, $urandom};
      mret_valid = ($urandom_range(0, 9) == 0);
      instret    = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        irq_meip = 1'($urandom); irq_msip = 1'($urandom); irq_mtip = 1'($urandom);
      end
      #1;
      check_all(c);
      tick();
    end

    // asynchronous reset in the middle of a cycle
    idle();
    rd_addr = 12'hB00;
    #2;
    rrst = 1;
    #1;
    chk("async_mcycle", rd_data, 64'd0);
    rd_addr = 12'h300;
    #1;
    chk("async_mstatus", rd_data, 64'hA_0000_1800);
    chk("async_irq_pend", 64'(irq_pend), 64'd0);
    model_reset();
    tick();
    rrst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
